// File: rtl/phold_pkg.sv
// Shared constants for the PHOLD result writer: MC command codes, FSM encodings
// and the result record geometry.
package phold_pkg;

   localparam logic [2:0] MC_CMD_WR       = 3'd2;
   localparam logic [2:0] MC_RSP_WR_CMPLT = 3'd3;
   localparam logic [1:0] MC_SIZE_8B      = 2'd3;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam int REC_WORDS = 4;

endpackage

// File: rtl/phold_result_writer_if.sv
// MC request/response port bundle; the writer is the master side.
interface phold_result_writer_if #(
   parameter int MC_RTNCTL_WIDTH = 32
);
   logic                       mc_rq_vld;
   logic [2:0]                 mc_rq_cmd;
   logic [3:0]                 mc_rq_scmd;
   logic [47:0]                mc_rq_vadr;
   logic [1:0]                 mc_rq_size;
   logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
   logic [63:0]                mc_rq_data;
   logic                       mc_rq_flush;
   logic                       mc_rq_stall;
   logic                       mc_rs_vld;
   logic [2:0]                 mc_rs_cmd;
   logic [3:0]                 mc_rs_scmd;
   logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
   logic [63:0]                mc_rs_data;
   logic                       mc_rs_stall;

   modport master (
      output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
             mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
      input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
             mc_rs_data
   );

   modport slave (
      input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
             mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
      output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
             mc_rs_data
   );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value; synchronous clear.
module sat_counter #(
   parameter int WID = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           inc,
   input  logic           clr,
   output logic [WID-1:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc && (value != {WID{1'b1}})) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/phold_result_writer.sv
// Counts PHOLD run statistics, then writes a 4-word result record (gvt, cycles,
// sent, received) to host memory and pulses done once every write has completed.
module phold_result_writer
   import phold_pkg::*;
#(
   parameter int MC_RTNCTL_WIDTH = 32,
   parameter int TIME_WID        = 16,
   parameter int CNT_WID         = 32,
   parameter int CYC_WID         = 48
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [47:0]           addr,
   input  logic [TIME_WID-1:0]   gvt,
   input  logic                  rtn_vld,
   input  logic                  evt_sent,
   input  logic                  evt_rcvd,
   output logic                  busy,
   output logic                  done,
   phold_result_writer_if.master mc
);

   logic [2:0]          state;
   logic [1:0]          idx;
   logic [2:0]          cmpl_cnt;
   logic [2:0]          cmpl_nxt;
   logic [TIME_WID-1:0] gvt_q;
   logic [47:0]         addr_q;
   logic [CYC_WID-1:0]  cyc_cnt;
   logic [CNT_WID-1:0]  sent_cnt;
   logic [CNT_WID-1:0]  rcvd_cnt;
   logic [63:0]         rec_word;
   logic                run_cnt;
   logic                accept;
   logic                rsp_ok;
   logic                cnt_clr;
   logic                unused_rs;

   // The cycle that sees rtn_vld is excluded from every statistic.
   assign run_cnt = (state == ST_RUN) && !rtn_vld;
   assign cnt_clr = (state == ST_DONE);
   assign accept  = (state == ST_WRITE) && !mc.mc_rq_stall;
   assign rsp_ok  = ((state == ST_WRITE) || (state == ST_WAIT)) && mc.mc_rs_vld &&
                    (mc.mc_rs_cmd == MC_RSP_WR_CMPLT) &&
                    (mc.mc_rs_rtnctl < MC_RTNCTL_WIDTH'(REC_WORDS));
   assign cmpl_nxt = cmpl_cnt + {2'b00, rsp_ok};

   sat_counter #(.WID(CYC_WID)) u_cyc_cnt (
      .clk(clk), .rst_n(rst_n), .inc(run_cnt), .clr(cnt_clr), .value(cyc_cnt)
   );
   sat_counter #(.WID(CNT_WID)) u_sent_cnt (
      .clk(clk), .rst_n(rst_n), .inc(run_cnt && evt_sent), .clr(cnt_clr), .value(sent_cnt)
   );
   sat_counter #(.WID(CNT_WID)) u_rcvd_cnt (
      .clk(clk), .rst_n(rst_n), .inc(run_cnt && evt_rcvd), .clr(cnt_clr), .value(rcvd_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         idx      <= '0;
         cmpl_cnt <= '0;
         gvt_q    <= '0;
         addr_q   <= '0;
      end else begin
         cmpl_cnt <= cmpl_nxt;
         case (state)
            ST_IDLE: if (start) state <= ST_RUN;
            ST_RUN: begin
               if (rtn_vld) begin
                  gvt_q    <= gvt;
                  addr_q   <= addr;
                  idx      <= '0;
                  cmpl_cnt <= '0;
                  state    <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (accept) begin
                  idx <= idx + 1'b1;
                  if (idx == 2'(REC_WORDS - 1)) state <= ST_WAIT;
               end
            end
            // Completions may already have arrived while words were still issuing.
            ST_WAIT: if (cmpl_nxt == 3'(REC_WORDS)) state <= ST_DONE;
            ST_DONE: begin
               cmpl_cnt <= '0;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rec_word = '0;
      case (idx)
         2'd0:    rec_word = 64'(gvt_q);
         2'd1:    rec_word = 64'(cyc_cnt);
         2'd2:    rec_word = 64'(sent_cnt);
         default: rec_word = 64'(rcvd_cnt);
      endcase
   end

   assign mc.mc_rq_vld    = (state == ST_WRITE);
   assign mc.mc_rq_cmd    = MC_CMD_WR;
   assign mc.mc_rq_scmd   = 4'd0;
   assign mc.mc_rq_size   = MC_SIZE_8B;
   assign mc.mc_rq_flush  = 1'b0;
   assign mc.mc_rq_vadr   = mc.mc_rq_vld ? (addr_q + 48'({idx, 3'b000})) : '0;
   assign mc.mc_rq_rtnctl = mc.mc_rq_vld ? MC_RTNCTL_WIDTH'(idx) : '0;
   assign mc.mc_rq_data   = mc.mc_rq_vld ? rec_word : '0;
   assign mc.mc_rs_stall  = 1'b0;

   assign busy = (state == ST_RUN) || (state == ST_WRITE) || (state == ST_WAIT);
   assign done = (state == ST_DONE);

   assign unused_rs = ^{mc.mc_rs_scmd, mc.mc_rs_data};

endmodule

// File: tb/tb_phold_result_writer.sv
// Directed bench for phold_result_writer: record contents, stall hold, completion
// ordering, counter saturation, ignored controls and mid-operation reset.
module tb_phold_result_writer;
   import phold_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, rtn_vld, evt_sent, evt_rcvd;
   logic [47:0] addr;
   logic [15:0] gvt;
   logic        stall, rs_vld;
   logic [2:0]  rs_cmd;
   logic [31:0] rs_tag;
   logic        busy1, done1, busy2, done2;

   int n_chk = 0;
   int n_fail = 0;

   logic [63:0] cap_data [4];
   logic [63:0] cap2_data[4];
   logic [47:0] cap_vadr [4];
   logic [31:0] cap_tag  [4];
   int          cap_n, cap_cyc;
   logic        held_bad;

   phold_result_writer_if #(.MC_RTNCTL_WIDTH(32)) m1 ();
   phold_result_writer_if #(.MC_RTNCTL_WIDTH(32)) m2 ();

   assign m1.mc_rq_stall  = stall;
   assign m1.mc_rs_vld    = rs_vld;
   assign m1.mc_rs_cmd    = rs_cmd;
   assign m1.mc_rs_scmd   = 4'd0;
   assign m1.mc_rs_rtnctl = rs_tag;
   assign m1.mc_rs_data   = 64'd0;
   assign m2.mc_rq_stall  = stall;
   assign m2.mc_rs_vld    = rs_vld;
   assign m2.mc_rs_cmd    = rs_cmd;
   assign m2.mc_rs_scmd   = 4'd0;
   assign m2.mc_rs_rtnctl = rs_tag;
   assign m2.mc_rs_data   = 64'd0;

   phold_result_writer #(.MC_RTNCTL_WIDTH(32), .TIME_WID(16), .CNT_WID(32), .CYC_WID(48)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .gvt(gvt), .rtn_vld(rtn_vld),
      .evt_sent(evt_sent), .evt_rcvd(evt_rcvd), .busy(busy1), .done(done1), .mc(m1.master)
   );

   phold_result_writer #(.MC_RTNCTL_WIDTH(32), .TIME_WID(16), .CNT_WID(4), .CYC_WID(48)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .gvt(gvt), .rtn_vld(rtn_vld),
      .evt_sent(evt_sent), .evt_rcvd(evt_rcvd), .busy(busy2), .done(done2), .mc(m2.master)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_rsp(input logic [2:0] cmd, input logic [31:0] tag);
      rs_vld = 1'b1;
      rs_cmd = cmd;
      rs_tag = tag;
      tick();
      rs_vld = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_rtn(input logic [15:0] g, input logic [47:0] a);
      rtn_vld = 1'b1;
      gvt     = g;
      addr    = a;
      tick();
      rtn_vld  = 1'b0;
      evt_sent = 1'b0;
      evt_rcvd = 1'b0;
   endtask

   // Accept words as the DUT offers them, optionally stalling one word for a while.
   task automatic collect(input int stall_word, input int stall_cycles);
      logic [63:0] ref_d;
      logic [47:0] ref_a;
      logic [31:0] ref_t;
      int sc;
      sc = 0; cap_n = 0; cap_cyc = 0; held_bad = 1'b0;
      ref_d = '0; ref_a = '0; ref_t = '0;
      for (int c = 0; c < 64 && cap_n < 4; c++) begin
         if (m1.mc_rq_vld) begin
            if (cap_n == stall_word && sc == 0) begin
               ref_d = m1.mc_rq_data; ref_a = m1.mc_rq_vadr; ref_t = m1.mc_rq_rtnctl;
            end
            if (cap_n == stall_word && sc > 0 &&
                (m1.mc_rq_data !== ref_d || m1.mc_rq_vadr !== ref_a || m1.mc_rq_rtnctl !== ref_t))
               held_bad = 1'b1;
            if (cap_n == stall_word && sc < stall_cycles) begin
               stall = 1'b1;
               sc++;
            end else begin
               stall = 1'b0;
               cap_data[cap_n]  = m1.mc_rq_data;
               cap2_data[cap_n] = m2.mc_rq_data;
               cap_vadr[cap_n]  = m1.mc_rq_vadr;
               cap_tag[cap_n]   = m1.mc_rq_rtnctl;
               cap_n++;
            end
         end
         tick();
         cap_cyc++;
      end
      stall = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 0; rtn_vld = 0; evt_sent = 0; evt_rcvd = 0;
      addr = '0; gvt = '0; stall = 0; rs_vld = 0; rs_cmd = '0; rs_tag = '0;
      tick(); tick();
      n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy1); end
      n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done1); end
      n_chk++; if (m1.mc_rq_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", m1.mc_rq_vld); end
      n_chk++; if (m1.mc_rq_data !== 64'd0 || m1.mc_rq_vadr !== 48'd0 || m1.mc_rq_rtnctl !== 32'd0) begin
         n_fail++; $display("FAIL reset_bus got data=%h vadr=%h tag=%h want all 0",
                            m1.mc_rq_data, m1.mc_rq_vadr, m1.mc_rq_rtnctl);
      end
      n_chk++; if (m1.mc_rs_stall !== 1'b0) begin n_fail++; $display("FAIL rs_stall got %b want 0", m1.mc_rs_stall); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [63:0] exp_d[4];
      logic early;
      exp_d = '{64'd16001, 64'd101, 64'd10, 64'd12};
      pulse_start();
      n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_run got %b want 1", busy1); end
      for (int i = 0; i < 101; i++) begin
         evt_sent = (i < 10);
         evt_rcvd = (i >= 7 && i < 19);
         tick();
      end
      evt_sent = 1'b1; evt_rcvd = 1'b1;
      pulse_rtn(16'd16001, 48'h1000);
      n_chk++; if (m1.mc_rq_vld !== 1'b1) begin n_fail++; $display("FAIL basic_vld_first got %b want 1", m1.mc_rq_vld); end
      collect(-1, 0);
      n_chk++; if (cap_n !== 4 || cap_cyc !== 4) begin
         n_fail++; $display("FAIL basic_b2b got words=%0d cycles=%0d want 4/4", cap_n, cap_cyc);
      end
      for (int w = 0; w < 4; w++) begin
         n_chk++;
         if (cap_data[w] !== exp_d[w] || cap_vadr[w] !== 48'h1000 + 48'(8 * w) || cap_tag[w] !== 32'(w)) begin
            n_fail++;
            $display("FAIL basic_word%0d got data=%0d vadr=%h tag=%0d want data=%0d vadr=%h tag=%0d",
                     w, cap_data[w], cap_vadr[w], cap_tag[w], exp_d[w], 48'h1000 + 48'(8 * w), w);
         end
      end
      n_chk++; if (m1.mc_rq_vld !== 1'b0 || busy1 !== 1'b1) begin
         n_fail++; $display("FAIL basic_wait got vld=%b busy=%b want 0/1", m1.mc_rq_vld, busy1);
      end
      early = 1'b0;
      for (int t = 0; t < 3; t++) begin
         send_rsp(MC_RSP_WR_CMPLT, 32'(t));
         if (done1 !== 1'b0) early = 1'b1;
      end
      n_chk++; if (early !== 1'b0) begin n_fail++; $display("FAIL basic_early_done got 1 want 0"); end
      send_rsp(MC_RSP_WR_CMPLT, 32'd3);
      n_chk++; if (done1 !== 1'b1 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL basic_done got done=%b busy=%b want 1/0", done1, busy1);
      end
      tick();
      n_chk++; if (done1 !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done1); end
   endtask

   task automatic test_stall_order();
      logic [63:0] exp_d[4];
      logic early;
      exp_d = '{64'hAB, 64'd3, 64'd1, 64'd2};
      pulse_start();
      evt_sent = 1; evt_rcvd = 1; tick();
      evt_sent = 0; evt_rcvd = 1; tick();
      evt_sent = 0; evt_rcvd = 0; tick();
      pulse_rtn(16'h00AB, 48'h1234_5678_9A08);
      collect(1, 5);
      n_chk++; if (cap_n !== 4 || cap_cyc !== 9) begin
         n_fail++; $display("FAIL stall_count got words=%0d cycles=%0d want 4/9", cap_n, cap_cyc);
      end
      n_chk++; if (held_bad !== 1'b0) begin n_fail++; $display("FAIL stall_hold got changed outputs want held"); end
      for (int w = 0; w < 4; w++) begin
         n_chk++;
         if (cap_data[w] !== exp_d[w] || cap_vadr[w] !== 48'h1234_5678_9A08 + 48'(8 * w) || cap_tag[w] !== 32'(w)) begin
            n_fail++;
            $display("FAIL stall_word%0d got data=%h vadr=%h tag=%0d want data=%h vadr=%h tag=%0d",
                     w, cap_data[w], cap_vadr[w], cap_tag[w], exp_d[w], 48'h1234_5678_9A08 + 48'(8 * w), w);
         end
      end
      early = 1'b0;
      send_rsp(MC_RSP_WR_CMPLT, 32'd3); if (done1 !== 1'b0) early = 1'b1;
      send_rsp(MC_RSP_WR_CMPLT, 32'd0); if (done1 !== 1'b0) early = 1'b1;
      send_rsp(3'd1, 32'd2);            if (done1 !== 1'b0) early = 1'b1;
      send_rsp(MC_RSP_WR_CMPLT, 32'd4); if (done1 !== 1'b0) early = 1'b1;
      send_rsp(MC_RSP_WR_CMPLT, 32'd2); if (done1 !== 1'b0) early = 1'b1;
      n_chk++; if (early !== 1'b0) begin n_fail++; $display("FAIL order_early_done got 1 want 0"); end
      send_rsp(MC_RSP_WR_CMPLT, 32'd1);
      n_chk++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL order_done got %b want 1", done1); end
      tick();
   endtask

   task automatic test_saturate();
      pulse_start();
      evt_sent = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      evt_sent = 1'b0;
      pulse_rtn(16'd5, 48'h40);
      collect(-1, 0);
      n_chk++; if (cap2_data[2] !== 64'd15) begin n_fail++; $display("FAIL sat_w2 got %0d want 15", cap2_data[2]); end
      n_chk++; if (cap_data[2] !== 64'd20) begin n_fail++; $display("FAIL wide_w2 got %0d want 20", cap_data[2]); end
      n_chk++; if (cap2_data[1] !== 64'd20 || cap2_data[3] !== 64'd0) begin
         n_fail++; $display("FAIL sat_w1w3 got %0d/%0d want 20/0", cap2_data[1], cap2_data[3]);
      end
      for (int t = 0; t < 4; t++) send_rsp(MC_RSP_WR_CMPLT, 32'(t));
      n_chk++; if (done1 !== 1'b1 || done2 !== 1'b1) begin
         n_fail++; $display("FAIL sat_done got %b/%b want 1/1", done1, done2);
      end
      tick();
   endtask

   task automatic test_ignored();
      rtn_vld = 1'b1; evt_sent = 1'b1;
      tick();
      rtn_vld = 1'b0;
      n_chk++; if (busy1 !== 1'b0 || m1.mc_rq_vld !== 1'b0) begin
         n_fail++; $display("FAIL idle_rtn got busy=%b vld=%b want 0/0", busy1, m1.mc_rq_vld);
      end
      tick(); tick();
      evt_sent = 1'b0;
      pulse_start();
      for (int i = 0; i < 5; i++) begin
         start = (i == 2);
         tick();
      end
      start = 1'b0;
      n_chk++; if (busy1 !== 1'b1 || m1.mc_rq_vld !== 1'b0) begin
         n_fail++; $display("FAIL run_start got busy=%b vld=%b want 1/0", busy1, m1.mc_rq_vld);
      end
      pulse_rtn(16'd7, 48'h80);
      collect(-1, 0);
      n_chk++; if (cap_data[1] !== 64'd5 || cap_data[2] !== 64'd0) begin
         n_fail++; $display("FAIL ignored_counts got cyc=%0d sent=%0d want 5/0", cap_data[1], cap_data[2]);
      end
      for (int t = 0; t < 4; t++) send_rsp(MC_RSP_WR_CMPLT, 32'(t));
      tick();
   endtask

   task automatic test_reset_mid();
      logic saw_done;
      pulse_start();
      for (int i = 0; i < 4; i++) tick();
      pulse_rtn(16'd9, 48'h200);
      collect(-1, 0);
      send_rsp(MC_RSP_WR_CMPLT, 32'd0);
      send_rsp(MC_RSP_WR_CMPLT, 32'd1);
      n_chk++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL mid_wait_busy got %b want 1", busy1); end
      rst_n = 1'b0;
      #2;
      n_chk++; if (busy1 !== 1'b0 || m1.mc_rq_vld !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset got busy=%b vld=%b want 0/0", busy1, m1.mc_rq_vld);
      end
      tick();
      rst_n = 1'b1;
      tick();
      saw_done = 1'b0;
      send_rsp(MC_RSP_WR_CMPLT, 32'd2); if (done1 !== 1'b0 || busy1 !== 1'b0) saw_done = 1'b1;
      send_rsp(MC_RSP_WR_CMPLT, 32'd3); if (done1 !== 1'b0 || busy1 !== 1'b0) saw_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done1 !== 1'b0 || busy1 !== 1'b0) saw_done = 1'b1;
      end
      n_chk++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL late_rsp got done/busy activity want none"); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall_order();
      test_saturate();
      test_ignored();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
